// File: rtl/sram_bus_arbiter.sv
// Shares one SRAM-like port between instruction fetch and load/store, one transaction in flight.
// Define ARB_RR_EN to alternate between requesters under contention; default is fixed data priority.
`timescale 1ns/1ps
module sram_bus_arbiter #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  inst_req,
    input  logic [ADDR_WIDTH-1:0] inst_addr,
    input  logic                  inst_cancel,
    output logic                  inst_addr_ok,
    output logic                  inst_data_ok,
    output logic [31:0]           inst_rdata,
    input  logic                  data_req,
    input  logic                  data_wr,
    input  logic [1:0]            data_size,
    input  logic [3:0]            data_wstrb,
    input  logic [ADDR_WIDTH-1:0] data_addr,
    input  logic [31:0]           data_wdata,
    output logic                  data_addr_ok,
    output logic                  data_data_ok,
    output logic [31:0]           data_rdata,
    output logic                  mem_req,
    output logic                  mem_wr,
    output logic [1:0]            mem_size,
    output logic [3:0]            mem_wstrb,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic                  mem_addr_ok,
    input  logic                  mem_data_ok,
    input  logic [31:0]           mem_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;
    typedef enum logic [1:0] {G_NONE, G_INST, G_DATA} grant_e;

    state_e state_q, state_d;
    grant_e grant_q, grant_d;
    grant_e pick;
    logic   drop_q, drop_d;
    logic   in_req, in_wait, sel_inst, sel_data;

`ifdef ARB_RR_EN
    grant_e last_q, last_d;

    // Under contention, serve whoever did not win last time.
    always_comb begin
        pick = G_NONE;
        if (data_req && inst_req)
            pick = (last_q == G_DATA) ? G_INST : G_DATA;
        else if (data_req)
            pick = G_DATA;
        else if (inst_req)
            pick = G_INST;
    end

    always_comb begin
        last_d = last_q;
        if (state_q == S_IDLE && pick != G_NONE)
            last_d = pick;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            last_q <= G_INST;
        else
            last_q <= last_d;
    end
`else
    // Data belongs to the older instruction, so it always wins.
    always_comb begin
        pick = G_NONE;
        if (data_req)
            pick = G_DATA;
        else if (inst_req)
            pick = G_INST;
    end
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            grant_q <= G_NONE;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            drop_q  <= drop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        drop_d  = drop_q;
        if (state_q != S_IDLE && grant_q == G_INST && inst_cancel)
            drop_d = 1'b1;
        case (state_q)
            S_IDLE: begin
                drop_d  = 1'b0;
                grant_d = G_NONE;
                if (pick != G_NONE) begin
                    grant_d = pick;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (mem_addr_ok)
                    state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mem_data_ok) begin
                    state_d = S_IDLE;
                    grant_d = G_NONE;
                    drop_d  = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = G_NONE;
                drop_d  = 1'b0;
            end
        endcase
    end

    assign in_req   = (state_q == S_REQ);
    assign in_wait  = (state_q == S_WAIT);
    assign sel_inst = (grant_q == G_INST);
    assign sel_data = (grant_q == G_DATA);

    // Port fields are driven only in REQ so idle/wait cycles present a quiet bus.
    always_comb begin
        mem_req   = 1'b0;
        mem_wr    = 1'b0;
        mem_size  = 2'd0;
        mem_wstrb = 4'd0;
        mem_addr  = '0;
        mem_wdata = 32'd0;
        if (in_req) begin
            mem_req = 1'b1;
            if (sel_data) begin
                mem_wr    = data_wr;
                mem_size  = data_size;
                mem_wstrb = data_wstrb;
                mem_addr  = data_addr;
                mem_wdata = data_wdata;
            end else if (sel_inst) begin
                mem_size  = 2'd2;
                mem_addr  = inst_addr;
            end
        end
    end

    assign inst_addr_ok = in_req && sel_inst && mem_addr_ok;
    assign data_addr_ok = in_req && sel_data && mem_addr_ok;
    // A cancel arriving with the data itself also kills the response.
    assign inst_data_ok = in_wait && sel_inst && mem_data_ok && !drop_q && !inst_cancel;
    assign data_data_ok = in_wait && sel_data && mem_data_ok;
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

endmodule
